aes_block_dispatch: RTL and testbench

//  Command consumer directly downstream of spi_slave.
//  - On each start pulse, latches usr_key, usr_addr, usr_loc and mode.
//  - Reads one 128-bit block, byte-serial, from on-chip SRAM at usr_addr.
//  - Hands the block and key to the AES core and waits for its result.
//  - Writes the 128-bit result back to SRAM at usr_loc. Sole SRAM master

---
 rtl/aes_block_dispatch.sv | 158 +++++++++++++++
 tb/tb_aes_block_dispatch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_dispatch.sv
// Purpose: takes one command from spi_slave, reads a 16-byte block from SRAM, runs the AES core on it, and writes the result back to SRAM.
// Latency: first SRAM read 1 cycle after start; aes_start 18 cycles after start; done 17 cycles after aes_done.
// Backpressure: none. A start while busy is dropped and flagged on err. The block is the only SRAM master while busy.
module aes_block_dispatch #(
    parameter int BLK_BYTES   = 16,
    parameter int AES_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [127:0] usr_key,
    input  logic [7:0]   usr_addr,
    input  logic [7:0]   usr_loc,
    output logic         mem_rd_en,
    output logic         mem_wr_en,
    output logic [7:0]   mem_addr,
    output logic [7:0]   mem_wdata,
    input  logic [7:0]   mem_rdata,
    output logic         aes_start,
    output logic         aes_mode,
    output logic [127:0] aes_key,
    output logic [127:0] aes_data,
    input  logic         aes_done,
    input  logic [127:0] aes_result,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int              TMO_W     = $clog2(AES_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(AES_TIMEOUT - 1);
    localparam logic [3:0]      LAST_BYTE = 4'(BLK_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_TAIL, S_KICK, S_WAIT, S_WRITE, S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt;
    logic [TMO_W-1:0]   tmo;
    logic [7:0]         addr_q;
    logic [7:0]         loc_q;
    logic               mode_q;
    logic [127:0]       key_q;
    logic [127:0]       data_q;
    logic [127:0]       res_q;
    logic               rd_vld_q;
    logic [3:0]         rd_idx_q;
    logic               err_q;
    logic               tmo_expire;

    // The AES core gave up: this is the last WAIT cycle allowed and no result arrived.
    assign tmo_expire = (state == S_WAIT) && !aes_done && (tmo == TMO_LAST);

    // State register. Reset aborts any operation in progress at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_READ;
            S_READ:  if (cnt == LAST_BYTE) state_nxt = S_TAIL;
            S_TAIL:  state_nxt = S_KICK;
            S_KICK:  state_nxt = S_WAIT;
            S_WAIT:  begin
                if (aes_done)        state_nxt = S_WRITE;
                else if (tmo_expire) state_nxt = S_IDLE;
            end
            S_WRITE: if (cnt == LAST_BYTE) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output strobes decode from state only, so reset clears them in the same cycle.
    // Byte i lives at bits [127-8i -: 8]; {~i, 3'b111} is that top bit for a 4-bit i.
    always_comb begin
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        aes_start = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_READ: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_q + {4'h0, cnt};
            end
            S_WRITE: begin
                mem_wr_en = 1'b1;
                mem_addr  = loc_q + {4'h0, cnt};
                mem_wdata = res_q[{~cnt, 3'b111} -: 8];
            end
            S_KICK:  aes_start = 1'b1;
            S_DONE:  done      = 1'b1;
            default: ;
        endcase
    end

    // Command latch, byte/timeout counters, read capture, result capture and err pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 4'h0;
            tmo      <= '0;
            addr_q   <= 8'h00;
            loc_q    <= 8'h00;
            mode_q   <= 1'b0;
            key_q    <= '0;
            data_q   <= '0;
            res_q    <= '0;
            rd_vld_q <= 1'b0;
            rd_idx_q <= 4'h0;
            err_q    <= 1'b0;
        end else begin
            // A start is accepted only in IDLE. In any other state, including DONE, it is an error.
            err_q <= (start && state != S_IDLE) || tmo_expire;

            if (state == S_IDLE && start) begin
                addr_q <= usr_addr;
                loc_q  <= usr_loc;
                mode_q <= mode;
                key_q  <= usr_key;
                cnt    <= 4'h0;
            end

            if (state == S_READ || state == S_WRITE)
                cnt <= cnt + 4'h1;

            if (state == S_KICK)
                tmo <= '0;
            else if (state == S_WAIT)
                tmo <= tmo + 1'b1;

            if (state == S_WAIT && aes_done) begin
                res_q <= aes_result;
                cnt   <= 4'h0;
            end

            // SRAM returns data one cycle after the strobe. The index travels with the strobe.
            rd_vld_q <= mem_rd_en;
            rd_idx_q <= cnt;
            if (rd_vld_q)
                data_q[{~rd_idx_q, 3'b111} -: 8] <= mem_rdata;
        end
    end

    assign aes_mode = mode_q;
    assign aes_key  = key_q;
    assign aes_data = data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_aes_block_dispatch.sv
// Directed bench for aes_block_dispatch.
// It contains a behavioural SRAM with 1-cycle read latency and stubs the AES core by driving aes_done by hand.
// Outputs are sampled 1 time unit after the rising edge.
module tb_aes_block_dispatch;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [127:0] usr_key;
    logic [7:0]   usr_addr;
    logic [7:0]   usr_loc;
    logic         mem_rd_en;
    logic         mem_wr_en;
    logic [7:0]   mem_addr;
    logic [7:0]   mem_wdata;
    logic [7:0]   mem_rdata;
    logic         aes_start;
    logic         aes_mode;
    logic [127:0] aes_key;
    logic [127:0] aes_data;
    logic         aes_done;
    logic [127:0] aes_result;
    logic         busy;
    logic         done;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    // SRAM model: the fill request loads sram[a] = a - fill_base.
    logic [7:0] sram [256];
    logic       do_fill = 1'b0;
    logic [7:0] fill_base = 8'h00;

    // Event counters (these exclude cycles while reset is asserted).
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, done_cnt = 0, err_cnt = 0, kick_cnt = 0;

    localparam logic [127:0] KEY_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] KEY_B = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
    localparam logic [127:0] KEY_C = 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C;

    aes_block_dispatch #(.BLK_BYTES(16), .AES_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .usr_key(usr_key),
        .usr_addr(usr_addr), .usr_loc(usr_loc), .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .aes_start(aes_start), .aes_mode(aes_mode),
        .aes_key(aes_key), .aes_data(aes_data), .aes_done(aes_done),
        .aes_result(aes_result), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (do_fill) begin
            for (int i = 0; i < 256; i++) sram[i] <= 8'(i) - fill_base;
        end else begin
            if (mem_rd_en) mem_rdata <= sram[mem_addr];
            if (mem_wr_en) sram[mem_addr] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en) rd_cnt++;
            if (mem_wr_en) wr_cnt++;
            if (mem_rd_en && mem_wr_en) both_cnt++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (aes_start) kick_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] b);
        fill_base = b;
        do_fill = 1'b1;
        tick();
        do_fill = 1'b0;
    endtask

    // On return the DUT is in cycle 1 after the start edge.
    task automatic go(input logic m, input logic [127:0] k, input logic [7:0] a, input logic [7:0] l);
        mode = m; usr_key = k; usr_addr = a; usr_loc = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_kick(output int c);
        c = 1;
        while (!aes_start && c < 100) begin tick(); c++; end
    endtask

    // Drives aes_done in the first WAIT cycle. On return the DUT is in cycle 1 after the aes_done edge.
    task automatic finish_aes(input logic [127:0] r);
        tick();
        aes_result = r; aes_done = 1'b1;
        tick();
        aes_done = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 1;
        while (!done && c < 100) begin tick(); c++; end
    endtask

    initial begin
        int c, w0, r0, d0, e0;
        rst = 1'b1; start = 1'b0; mode = 1'b0; usr_key = '0; usr_addr = 8'h00;
        usr_loc = 8'h00; aes_done = 1'b0; aes_result = '0;
        #2;
        chk("reset_outs", 128'({mem_rd_en, mem_wr_en, mem_addr, mem_wdata, aes_start, aes_mode, busy, done, err}), 128'h0);
        chk("reset_key", aes_key, 128'h0);
        chk("reset_data", aes_data, 128'h0);
        tick();
        rst = 1'b0;
        fill(8'h10);

        // Encrypt: SRAM[0x10..0x1F] = 00..0F, result goes to 0x40.
        w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
        go(1'b0, KEY_A, 8'h10, 8'h40);
        chk("enc_first_rd_en", 128'(mem_rd_en), 128'h1);
        chk("enc_first_rd_addr", 128'(mem_addr), 128'h10);
        chk("enc_busy", 128'(busy), 128'h1);
        wait_kick(c);
        chk("enc_kick_latency", 128'(c), 128'd18);
        chk("enc_data", aes_data, 128'h00010203_04050607_08090A0B_0C0D0E0F);
        chk("enc_key", aes_key, KEY_A);
        chk("enc_mode", 128'(aes_mode), 128'h0);
        chk("enc_addr_idle_kick", 128'(mem_addr), 128'h0);
        finish_aes(128'hFFFEFDFC_FBFAF9F8_F7F6F5F4_F3F2F1F0);
        wait_done(c);
        chk("enc_done_latency", 128'(c), 128'd17);
        tick();
        chk("enc_done_one_cycle", 128'(done), 128'h0);
        chk("enc_busy_after", 128'(busy), 128'h0);
        chk("enc_sram_40", 128'(sram[8'h40]), 128'hFF);
        chk("enc_sram_47", 128'(sram[8'h47]), 128'hF8);
        chk("enc_sram_4f", 128'(sram[8'h4F]), 128'hF0);
        chk("enc_sram_50_untouched", 128'(sram[8'h50]), 128'h40);
        chk("enc_sram_3f_untouched", 128'(sram[8'h3F]), 128'h2F);
        chk("enc_rd_count", 128'(rd_cnt - r0), 128'd16);
        chk("enc_wr_count", 128'(wr_cnt - w0), 128'd16);
        chk("enc_done_count", 128'(done_cnt - d0), 128'd1);

        // Address wrap with overlapping source and destination ranges.
        fill(8'h00);
        go(1'b0, KEY_A, 8'hF8, 8'hFC);
        wait_kick(c);
        chk("wrap_data", aes_data, 128'hF8F9FAFB_FCFDFEFF_00010203_04050607);
        finish_aes(128'h11223344_55667788_99AABBCC_DDEEFF00);
        wait_done(c);
        tick();
        chk("wrap_sram_fc", 128'(sram[8'hFC]), 128'h11);
        chk("wrap_sram_ff", 128'(sram[8'hFF]), 128'h44);
        chk("wrap_sram_00", 128'(sram[8'h00]), 128'h55);
        chk("wrap_sram_0b", 128'(sram[8'h0B]), 128'h00);
        chk("wrap_sram_0c_untouched", 128'(sram[8'h0C]), 128'h0C);
        chk("wrap_sram_fb_untouched", 128'(sram[8'hFB]), 128'hFB);

        // Start while busy, issued during WAIT.
        fill(8'h20);
        e0 = err_cnt; w0 = wr_cnt;
        go(1'b0, KEY_B, 8'h30, 8'h80);
        wait_kick(c);
        tick();
        mode = 1'b1; usr_key = KEY_C; usr_addr = 8'h99; usr_loc = 8'h77;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_err_pulse", 128'(err), 128'h1);
        chk("busy_still_busy", 128'(busy), 128'h1);
        tick();
        chk("busy_err_one_cycle", 128'(err), 128'h0);
        chk("busy_key_kept", aes_key, KEY_B);
        chk("busy_mode_kept", 128'(aes_mode), 128'h0);
        aes_result = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0; aes_done = 1'b1;
        tick();
        aes_done = 1'b0;
        wait_done(c);
        chk("busy_done_latency", 128'(c), 128'd17);
        tick();
        chk("busy_data_kept", aes_data, 128'h10111213_14151617_18191A1B_1C1D1E1F);
        chk("busy_sram_80", 128'(sram[8'h80]), 128'h0F);
        chk("busy_sram_8f", 128'(sram[8'h8F]), 128'hF0);
        chk("busy_sram_77_untouched", 128'(sram[8'h77]), 128'h57);
        chk("busy_err_count", 128'(err_cnt - e0), 128'd1);
        chk("busy_wr_count", 128'(wr_cnt - w0), 128'd16);

        // Timeout: aes_done never arrives.
        w0 = wr_cnt;
        go(1'b0, KEY_A, 8'h00, 8'hA0);
        wait_kick(c);
        while (!err && c < 200) begin tick(); c++; end
        chk("tmo_err_cycle", 128'(c), 128'd83);
        chk("tmo_busy_clear", 128'(busy), 128'h0);
        chk("tmo_no_write", 128'(wr_cnt - w0), 128'd0);
        tick();
        chk("tmo_err_one_cycle", 128'(err), 128'h0);

        // Decrypt with the FIPS-197 key, then a start issued in the DONE cycle.
        go(1'b1, KEY_C, 8'h00, 8'hC0);
        chk("dec_key_latched", aes_key, KEY_C);
        chk("dec_mode_latched", 128'(aes_mode), 128'h1);
        wait_kick(c);
        chk("dec_key_kick", aes_key, KEY_C);
        chk("dec_mode_kick", 128'(aes_mode), 128'h1);
        finish_aes(128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A);
        chk("dec_key_write", aes_key, KEY_C);
        wait_done(c);
        r0 = rd_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start_err", 128'(err), 128'h1);
        chk("done_start_idle", 128'(busy), 128'h0);
        tick(); tick();
        chk("done_start_no_read", 128'(rd_cnt - r0), 128'd0);
        chk("dec_key_held", aes_key, KEY_C);
        chk("dec_mode_held", 128'(aes_mode), 128'h1);

        // aes_done outside WAIT is ignored.
        w0 = wr_cnt;
        aes_done = 1'b1;
        tick();
        aes_done = 1'b0;
        tick(); tick();
        chk("stray_aes_done_idle", 128'(busy), 128'h0);
        chk("stray_aes_done_no_write", 128'(wr_cnt - w0), 128'd0);

        // Reset in the middle of READ.
        go(1'b0, KEY_B, 8'h10, 8'h40);
        repeat (5) tick();
        chk("midrst_reading", 128'(mem_rd_en), 128'h1);
        rst = 1'b1;
        #1;
        chk("midrst_outs", 128'({mem_rd_en, mem_wr_en, mem_addr, mem_wdata, aes_start, aes_mode, busy, done, err}), 128'h0);
        chk("midrst_key", aes_key, 128'h0);
        chk("midrst_data", aes_data, 128'h0);
        tick();
        rst = 1'b0;
        r0 = rd_cnt; w0 = wr_cnt; e0 = kick_cnt;
        repeat (6) tick();
        chk("midrst_idle", 128'(busy), 128'h0);
        chk("midrst_no_strobes", 128'((rd_cnt - r0) + (wr_cnt - w0) + (kick_cnt - e0)), 128'd0);

        chk("never_rd_and_wr", 128'(both_cnt), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
